wb_i2c_reg_slave: RTL and testbench
===================================

Name: wb_i2c_reg_slave

Overview:
Wishbone slave register front-end of the I2C master controller. It is driven directly by the bench's Wishbone master BFM. It decodes the four-register map (CSR, DPR, CMDR, FSMR) and hands byte-level commands to the downstream I2C byte engine through a valid/ready handshake. It captures the engine's completion status and raises the interrupt back to the Wishbone side.

Parameters:
ADDR_WIDTH, 2, Wishbone address width; only offsets 0..3 are decoded.
DATA_WIDTH, 8, Wishbone data width; the register map is defined for 8.

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous, active-low reset
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe
we_i  in  1  Wishbone write enable
adr_i  in  ADDR_WIDTH  register offset
dat_i  in  DATA_WIDTH  write data
dat_o  out  DATA_WIDTH  read data, valid while ack_o=1
ack_o  out  1  single-cycle acknowledge
irq_o  out  1  level interrupt
cmd_valid_o  out  1  command request to byte engine
cmd_ready_i  in  1  byte engine accepts command
cmd_code_o  out  3  command code (CMDR[2:0])
cmd_data_o  out  8  byte to transmit (DPR)
rsp_valid_i  in  1  one-cycle completion pulse from engine
rsp_status_i  in  3  {NAK, AL, ERR} for the completed command
rsp_data_i  in  8  received byte
bus_busy_i  in  1  I2C bus busy
bus_cap_i  in  1  bus captured by this master
fsm_state_i  in  8  engine FSM encoding, mirrored into FSMR

Behaviour:
- Reset (rst_i=0 at clk edge):
  - ack_o=0, dat_o=0, irq_o=0, cmd_valid_o=0, cmd_code_o=0, cmd_data_o=0.
  - All register fields 0; internal state IDLE; irq_pending=0.
- Bus access:
  - A request is `cyc_i & stb_i & !ack_o`.
  - ack_o rises on the first edge where the request is seen (1-cycle latency) and is high for exactly one cycle.
  - Register write side-effects and the dat_o load happen on that same edge.
  - Back-to-back accesses are acked every other cycle.
  - cyc_i or stb_i dropping before ack: no ack, no side effect.
- Register map:
  - CSR, offset 0:
    - [7] E enable, RW; [6] IE interrupt enable, RW; [3:0] bus ID, RW.
    - [5] BB = bus_busy_i, RO; [4] BC = bus_cap_i, RO. Writes to [5:4] are ignored.
  - DPR, offset 1:
    - Write loads cmd_data_o.
    - Read returns the last captured rsp_data_i (0 after reset).
  - CMDR, offset 2:
    - Read returns [7] DON, [6] NAK, [5] AL, [4] ERR, [3] 0, [2:0] last command code.
    - Reading CMDR clears irq_pending.
  - FSMR, offset 3:
    - Read returns fsm_state_i, sampled at the ack edge.
    - Write is acked with no effect.
- Command state machine (IDLE, REQ, WAIT):
  - IDLE, CMDR write with E=1:
    - Latch dat_i[2:0] into cmd_code_o and clear DON/NAK/AL/ERR.
    - Assert cmd_valid_o on the same edge; go to REQ.
  - IDLE, CMDR write with E=0:
    - No command issued. Set DON=0, ERR=1, irq_pending=1.
  - REQ:
    - Hold cmd_valid_o, cmd_code_o and cmd_data_o stable until an edge with cmd_ready_i=1.
    - On that edge drop cmd_valid_o and go to WAIT.
  - WAIT, on rsp_valid_i=1:
    - DON=1; NAK/AL/ERR taken from rsp_status_i.
    - DPR read value takes rsp_data_i.
    - irq_pending=1; go to IDLE.
  - CMDR write in REQ or WAIT: acked and ignored; no status change.
  - Same-edge CMDR write and rsp_valid_i in WAIT: the response is captured and the write is ignored.
  - rsp_valid_i in IDLE or REQ: ignored.
  - CSR write clearing E while in REQ or WAIT (abort):
    - cmd_valid_o=0, state to IDLE.
    - Status bits unchanged; no irq_pending set.
  - DPR write in REQ: cmd_data_o is not updated until the state returns to IDLE.
- Interrupt:
  - irq_o registered: irq_o = irq_pending & IE & E, one cycle after its inputs.
  - Setting and clearing irq_pending on the same edge: set wins.
- Reset mid-operation returns everything to reset values in one edge, regardless of state.

Test Plan:
1. Release reset, then read offsets 0..3 with fsm_state_i=8'h00 and bus inputs 0 -> all reads return 8'h00; ack_o seen exactly one cycle per access; irq_o=0.
2. Write CSR=8'hFF, then read -> 8'hCF with bus_busy_i=0 and bus_cap_i=0; drive bus_busy_i=1 and re-read -> 8'hEF.
3. Write CSR=8'hC0, DPR=8'h44, CMDR=8'h01 -> cmd_valid_o=1, cmd_code_o=1, cmd_data_o=8'h44. Continue:
   - Hold cmd_ready_i=0 for 3 cycles -> signals stay stable.
   - Assert cmd_ready_i, then pulse rsp_valid_i with status 3'b100 and data 8'hA5 -> irq_o=1 next cycle.
   - Read CMDR -> 8'hC1; irq_o drops. Read DPR -> 8'hA5.
4. CSR=8'h40 (E=0), write CMDR=8'h02 -> cmd_valid_o stays 0; CMDR read -> 8'h10; irq_o stays 0 because E=0.
5. With E=1, issue a command, then write CMDR=8'h05 while in WAIT -> ignored; the later response shows code 1. Then in REQ write CSR=8'h00 -> cmd_valid_o=0 next edge; no irq_o.
6. Write FSMR=8'hFF with fsm_state_i=8'h3C, then read FSMR -> 8'h3C. Pull rst_i low for one edge mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/wb_i2c_reg_slave.sv
// wb_i2c_reg_slave: Wishbone register front-end issuing byte commands to the I2C engine
module wb_i2c_reg_slave #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_code_o,
  output logic [7:0]            cmd_data_o,
  input  logic                  rsp_valid_i,
  input  logic [2:0]            rsp_status_i,
  input  logic [7:0]            rsp_data_i,
  input  logic                  bus_busy_i,
  input  logic                  bus_cap_i,
  input  logic [7:0]            fsm_state_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic req, wr, rd, csr_wr, dpr_wr, cmdr_wr, cmdr_rd, abort, issue, reject, done;
  logic csr_e, csr_ie, don, nak, al, err, irq_pending;
  logic [3:0] csr_id;
  logic [7:0] dpr_rd, dpr_sh, rd_mux;
  always_comb begin
    req = cyc_i & stb_i & ~ack_o;
    wr = req & we_i;
    rd = req & ~we_i;
    csr_wr = wr & (adr_i == ADDR_WIDTH'(0));
    dpr_wr = wr & (adr_i == ADDR_WIDTH'(1));
    cmdr_wr = wr & (adr_i == ADDR_WIDTH'(2));
    cmdr_rd = rd & (adr_i == ADDR_WIDTH'(2));
    abort = csr_wr & ~dat_i[7] & (state != IDLE);
    issue = cmdr_wr & csr_e & (state == IDLE);
    reject = cmdr_wr & ~csr_e & (state == IDLE);
    done = rsp_valid_i & (state == WAIT);
    state_n = state == IDLE ? (issue ? REQ : IDLE) :
              state == REQ  ? (abort ? IDLE : cmd_ready_i ? WAIT : REQ) :
              (done | abort) ? IDLE : WAIT;
    rd_mux = adr_i == ADDR_WIDTH'(0) ? {csr_e, csr_ie, bus_busy_i, bus_cap_i, csr_id} :
             adr_i == ADDR_WIDTH'(1) ? dpr_rd :
             adr_i == ADDR_WIDTH'(2) ? {don, nak, al, err, 1'b0, cmd_code_o} : fsm_state_i;
  end
  always_ff @(posedge clk_i)
    state <= !rst_i ? IDLE : state_n;
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      irq_o <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_code_o <= '0;
      cmd_data_o <= '0;
      {csr_e, csr_ie, csr_id} <= '0;
      {don, nak, al, err, irq_pending} <= '0;
      dpr_rd <= '0;
      dpr_sh <= '0;
    end else begin
      ack_o <= req;
      dat_o <= rd ? DATA_WIDTH'(rd_mux) : '0;
      irq_o <= irq_pending & csr_ie & csr_e;
      cmd_valid_o <= state_n == REQ;
      irq_pending <= reject | done | (irq_pending & ~cmdr_rd);
      if (csr_wr) {csr_e, csr_ie, csr_id} <= {dat_i[7:6], dat_i[3:0]};
      if (dpr_wr) dpr_sh <= dat_i[7:0];
      if (state == IDLE) cmd_data_o <= dpr_wr ? dat_i[7:0] : dpr_sh;
      if (issue) begin
        cmd_code_o <= dat_i[2:0];
        {don, nak, al, err} <= '0;
      end
      if (reject) {don, err} <= 2'b01;
      if (done) begin
        don <= 1'b1;
        {nak, al, err} <= rsp_status_i;
        dpr_rd <= rsp_data_i;
      end
    end
endmodule

// File: tb/tb_wb_i2c_reg_slave.sv
// tb_wb_i2c_reg_slave: directed scoreboard bench for the Wishbone I2C register front-end
module tb_wb_i2c_reg_slave;
  logic clk_i = 1'b0, rst_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [1:0] adr_i = '0;
  logic [7:0] dat_i = '0, dat_o, cmd_data_o, rsp_data_i = '0, fsm_state_i = '0;
  logic ack_o, irq_o, cmd_valid_o, cmd_ready_i = 1'b0, rsp_valid_i = 1'b0;
  logic bus_busy_i = 1'b0, bus_cap_i = 1'b0;
  logic [2:0] cmd_code_o, rsp_status_i = '0;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;
  wb_i2c_reg_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_code_o(cmd_code_o),
    .cmd_data_o(cmd_data_o), .rsp_valid_i(rsp_valid_i), .rsp_status_i(rsp_status_i),
    .rsp_data_i(rsp_data_i), .bus_busy_i(bus_busy_i), .bus_cap_i(bus_cap_i),
    .fsm_state_i(fsm_state_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] e);
    int n = 0;
    if (!w) exp_q.push_back(e);
    step();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    do begin
      step();
      n++;
    end while (!ack_o && n < 8);
    chk("ack_latency", 8'(n), 8'd1);
    if (!w) chk($sformatf("read_adr%0d", a), dat_o, exp_q.pop_front());
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step();
    chk("ack_one_cycle", {7'b0, ack_o}, 8'd0);
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_ack"}, {7'b0, ack_o}, 8'd0);
    chk({tag, "_dat"}, dat_o, 8'd0);
    chk({tag, "_irq"}, {7'b0, irq_o}, 8'd0);
    chk({tag, "_valid"}, {7'b0, cmd_valid_o}, 8'd0);
    chk({tag, "_code"}, {5'b0, cmd_code_o}, 8'd0);
    chk({tag, "_data"}, cmd_data_o, 8'd0);
  endtask
  task automatic rsp(input logic [2:0] s, input logic [7:0] d);
    rsp_valid_i = 1'b1; rsp_status_i = s; rsp_data_i = d;
    step();
    rsp_valid_i = 1'b0; rsp_status_i = '0; rsp_data_i = '0;
  endtask
  initial begin
    int acks;
    repeat (3) step();
    rst_chk("reset");
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) xfer(1'b0, 2'(i), 8'h00, 8'h00);
    chk("t1_irq", {7'b0, irq_o}, 8'd0);
    xfer(1'b1, 2'd0, 8'hFF, 8'h00);
    xfer(1'b0, 2'd0, 8'h00, 8'hCF);
    bus_busy_i = 1'b1;
    xfer(1'b0, 2'd0, 8'h00, 8'hEF);
    bus_busy_i = 1'b0;
    acks = 0;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 2'd0;
    repeat (4) begin
      step();
      acks += int'(ack_o);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    chk("back_to_back_acks", 8'(acks), 8'd2);
    step();
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 2'd0; dat_i = 8'h00;
    #2;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step();
    chk("dropped_no_ack", {7'b0, ack_o}, 8'd0);
    xfer(1'b0, 2'd0, 8'h00, 8'hCF);
    xfer(1'b1, 2'd0, 8'hC0, 8'h00);
    xfer(1'b1, 2'd1, 8'h44, 8'h00);
    xfer(1'b1, 2'd2, 8'h01, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid", {7'b0, cmd_valid_o}, 8'd1);
      chk("t3_code", {5'b0, cmd_code_o}, 8'd1);
      chk("t3_data", cmd_data_o, 8'h44);
      step();
    end
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    chk("t3_valid_drop", {7'b0, cmd_valid_o}, 8'd0);
    rsp(3'b100, 8'hA5);
    step();
    chk("t3_irq_set", {7'b0, irq_o}, 8'd1);
    xfer(1'b0, 2'd2, 8'h00, 8'hC1);
    chk("t3_irq_clear", {7'b0, irq_o}, 8'd0);
    xfer(1'b0, 2'd1, 8'h00, 8'hA5);
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    xfer(1'b1, 2'd0, 8'h40, 8'h00);
    xfer(1'b1, 2'd2, 8'h02, 8'h00);
    chk("t4_no_valid", {7'b0, cmd_valid_o}, 8'd0);
    xfer(1'b0, 2'd2, 8'h00, 8'h10);
    chk("t4_irq", {7'b0, irq_o}, 8'd0);
    xfer(1'b1, 2'd0, 8'hC0, 8'h00);
    xfer(1'b1, 2'd2, 8'h01, 8'h00);
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    xfer(1'b1, 2'd2, 8'h05, 8'h00);
    chk("t5_wait_code", {5'b0, cmd_code_o}, 8'd1);
    chk("t5_wait_valid", {7'b0, cmd_valid_o}, 8'd0);
    rsp(3'b000, 8'h5A);
    xfer(1'b0, 2'd2, 8'h00, 8'h81);
    chk("t5_irq_clear", {7'b0, irq_o}, 8'd0);
    xfer(1'b1, 2'd2, 8'h03, 8'h00);
    chk("t5_req_valid", {7'b0, cmd_valid_o}, 8'd1);
    xfer(1'b1, 2'd1, 8'h77, 8'h00);
    chk("t5_req_data_held", cmd_data_o, 8'h00);
    xfer(1'b1, 2'd0, 8'h00, 8'h00);
    chk("t5_abort_valid", {7'b0, cmd_valid_o}, 8'd0);
    chk("t5_data_after_idle", cmd_data_o, 8'h77);
    xfer(1'b0, 2'd2, 8'h00, 8'h03);
    chk("t5_abort_irq", {7'b0, irq_o}, 8'd0);
    rsp(3'b111, 8'hFF);
    xfer(1'b0, 2'd2, 8'h00, 8'h03);
    xfer(1'b0, 2'd1, 8'h00, 8'h5A);
    fsm_state_i = 8'h3C;
    xfer(1'b1, 2'd3, 8'hFF, 8'h00);
    xfer(1'b0, 2'd3, 8'h00, 8'h3C);
    fsm_state_i = 8'h00;
    xfer(1'b1, 2'd0, 8'hC0, 8'h00);
    xfer(1'b1, 2'd1, 8'h12, 8'h00);
    xfer(1'b1, 2'd2, 8'h01, 8'h00);
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    chk("t6_wait_data", cmd_data_o, 8'h12);
    rst_i = 1'b0;
    step();
    rst_chk("mid_reset");
    rst_i = 1'b1;
    rsp(3'b111, 8'hEE);
    xfer(1'b0, 2'd0, 8'h00, 8'h00);
    xfer(1'b0, 2'd2, 8'h00, 8'h00);
    xfer(1'b0, 2'd1, 8'h00, 8'h00);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
